// File: rtl/mem_writeback.sv
// Memory access / writeback stage: IDLE -> REQ -> RESP handshake with load timeout.
// Optional MISALIGNED_TRAP_EN traps misaligned half/word accesses instead of issuing them.
module mem_writeback #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_we,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        bus_err,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [7:0] LAST = 8'(MAX_WAIT - 1);

  state_t      state_q;
  logic [31:0] addr_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic [3:0]  mask_q;
  logic [2:0]  f3_q;
  logic        ld_q;
  logic        rwe_q;
  logic [4:0]  rd_q;
  logic [7:0]  cnt_q;
  logic        wb_we_q;
  logic [4:0]  wb_rd_q;
  logic [31:0] wb_data_q;
  logic        bus_err_q;

  logic        mem_op;
  logic        mis_d;
  logic [3:0]  mask_d;
  logic [31:0] wdata_d;
  logic [31:0] ld_data_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign mem_op = ex_is_load | ex_is_store;

  always_comb begin
    mask_d  = 4'b1111;
    wdata_d = ex_store_data;
    case (ex_funct3[1:0])
      2'b00: begin
        mask_d  = 4'b0001 << ex_result[1:0];
        wdata_d = {4{ex_store_data[7:0]}};
      end
      2'b01: begin
        mask_d  = 4'b0011 << {ex_result[1], 1'b0};
        wdata_d = {2{ex_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_v = dmem_rdata[{off_q, 3'b000} +: 8];
  assign half_v = dmem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (f3_q)
      3'd0:    ld_data_d = {{24{byte_v[7]}}, byte_v};
      3'd1:    ld_data_d = {{16{half_v[15]}}, half_v};
      3'd4:    ld_data_d = {24'd0, byte_v};
      3'd5:    ld_data_d = {16'd0, half_v};
      default: ld_data_d = dmem_rdata;
    endcase
  end

`ifdef MISALIGNED_TRAP_EN
  logic mis_q;

  assign mis_d = mem_op
               & ((ex_funct3[1:0] == 2'b01 & ex_result[0])
               |  (ex_funct3[1] & |ex_result[1:0]));

  always_ff @(posedge clk) begin
    if (rst) mis_q <= 1'b0;
    else     mis_q <= (state_q == IDLE) & ex_valid & mis_d;
  end

  assign misaligned = mis_q;
`else
  assign mis_d      = 1'b0;
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      mask_q    <= '0;
      f3_q      <= '0;
      ld_q      <= 1'b0;
      rwe_q     <= 1'b0;
      rd_q      <= '0;
      cnt_q     <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      wb_we_q   <= 1'b0;
      bus_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ex_valid && mem_op) begin
            if (!mis_d) begin
              state_q <= REQ;
              addr_q  <= {ex_result[31:2], 2'b00};
              off_q   <= ex_result[1:0];
              wdata_q <= wdata_d;
              mask_q  <= ex_is_load ? 4'b0000 : mask_d;
              f3_q    <= ex_funct3;
              ld_q    <= ex_is_load;
              rwe_q   <= ex_reg_we;
              rd_q    <= ex_rd;
            end
          end else if (ex_valid) begin
            wb_we_q   <= ex_reg_we;
            wb_rd_q   <= ex_rd;
            wb_data_q <= ex_result;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            state_q <= ld_q ? RESP : IDLE;
            cnt_q   <= '0;
          end
        end
        RESP: begin
          // Data arriving on the timeout cycle still completes the load.
          if (dmem_rvalid) begin
            wb_we_q   <= rwe_q;
            wb_rd_q   <= rd_q;
            wb_data_q <= ld_data_d;
            state_q   <= IDLE;
          end else if (cnt_q == LAST) begin
            bus_err_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall      = (state_q != IDLE);
  assign dmem_req   = (state_q == REQ);
  assign dmem_we    = (state_q == REQ) & ~ld_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wmask = mask_q;
  assign wb_we      = wb_we_q;
  assign wb_rd      = wb_rd_q;
  assign wb_data    = wb_data_q;
  assign bus_err    = bus_err_q;

endmodule
